scaler_capture_ctrl: RTL

Sequences the downscaled-frame buffer between the CCD capture path and its consumers. On command, it arms on the next sensor frame start and generates the sample strobes and write addresses for the 20x20 grid. It flags completion and then shares the buffer read port between the face detector and the VGA preview. Sits between CCD_Capture/X-Y counters and the scaler register file.

---
 rtl/scaler_pkg.sv | 20 ++
 rtl/scaler_rd_arb.sv | 52 +++++
 rtl/scaler_capture_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
// Shared types and default geometry for the downscaled-frame capture controller.
package scaler_pkg;

  localparam int GRID_W    = 20;
  localparam int GRID_H    = 20;
  localparam int X_STEP    = 64;
  localparam int Y_STEP    = 48;
  localparam int ADDR_W    = 9;
  localparam int BUF_DEPTH = GRID_W * GRID_H;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CAPT  = 2'd2,
    READY = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/scaler_rd_arb.sv
// Two-requester read-port arbiter (detector / preview), registered grant.
// Macro SCALER_ARB_RR_EN selects round-robin; otherwise the detector has fixed priority.
module scaler_rd_arb #(
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              en,
  input  logic              det_req,
  input  logic [ADDR_W-1:0] det_addr,
  input  logic              pv_req,
  input  logic [ADDR_W-1:0] pv_addr,
  output logic              det_gnt,
  output logic              pv_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr
);
  import scaler_pkg::*;

  logic pick_det;

`ifdef SCALER_ARB_RR_EN
  // Set when the preview held the port last; starts set so the detector goes first.
  logic last_pv;

  assign pick_det = det_req & (~pv_req | last_pv);

  always_ff @(posedge CLK) begin
    if (RESET)                     last_pv <= 1'b1;
    else if (en & (det_req | pv_req)) last_pv <= ~pick_det;
  end
`else
  assign pick_det = det_req;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      det_gnt <= 1'b0;
      pv_gnt  <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      det_gnt <= en & pick_det;
      pv_gnt  <= en & pv_req & ~pick_det;
      rd_en   <= en & (det_req | pv_req);
      if (en & pick_det)    rd_addr <= det_addr;
      else if (en & pv_req) rd_addr <= pv_addr;
      else                  rd_addr <= '0;
    end
  end

endmodule

// File: rtl/scaler_capture_ctrl.sv
// Capture sequencer for the 20x20 downscaled buffer: arms on START, strobes grid samples
// from the sensor raster, then shares the buffer read port (see scaler_rd_arb).
module scaler_capture_ctrl #(
  parameter int GRID_W = 20,
  parameter int GRID_H = 20,
  parameter int X_STEP = 64,
  parameter int Y_STEP = 48,
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              FRAME_VALID,
  input  logic              PIXEL_VALID,
  input  logic [15:0]       X_Cont,
  input  logic [15:0]       Y_Cont,
  input  logic              RELEASE,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              BUSY,
  output logic              READY,
  output logic              DONE,
  output logic              ERR,
  input  logic              DET_REQ,
  input  logic [ADDR_W-1:0] DET_ADDR,
  output logic              DET_GNT,
  input  logic              PV_REQ,
  input  logic [ADDR_W-1:0] PV_ADDR,
  output logic              PV_GNT,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR
);
  import scaler_pkg::*;

  localparam logic [16:0]       XS    = 17'(X_STEP);
  localparam logic [16:0]       YS    = 17'(Y_STEP);
  localparam logic [15:0]       X_LIM = 16'(GRID_W * X_STEP);
  localparam logic [15:0]       Y_LIM = 16'(GRID_H * Y_STEP);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(GRID_W * GRID_H - 1);

  ctrl_state_t       state;
  logic              fv_q, fv_rise, fv_fall;
  logic [15:0]       xb, yb, xb_nxt, yb_nxt;
  logic [ADDR_W-1:0] wcnt;
  logic              full, samp;

  assign fv_rise = FRAME_VALID & ~fv_q;
  assign fv_fall = ~FRAME_VALID & fv_q;

  // Phase trackers: xb/yb follow the largest step multiple not above the sensor
  // coordinate, so a coordinate is on-grid exactly when it equals the tracked base.
  always_comb begin
    xb_nxt = xb;
    yb_nxt = yb;
    if (X_Cont < xb)                        xb_nxt = '0;
    else if ({1'b0, X_Cont} >= {1'b0, xb} + XS) xb_nxt = 16'({1'b0, xb} + XS);
    if (Y_Cont < yb)                        yb_nxt = '0;
    else if ({1'b0, Y_Cont} >= {1'b0, yb} + YS) yb_nxt = 16'({1'b0, yb} + YS);
  end

  assign samp = (state == CAPT) && PIXEL_VALID && (X_Cont == xb_nxt) && (Y_Cont == yb_nxt) &&
                (X_Cont < X_LIM) && (Y_Cont < Y_LIM);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      fv_q    <= 1'b0;
      xb      <= '0;
      yb      <= '0;
      wcnt    <= '0;
      full    <= 1'b0;
      WR_EN   <= 1'b0;
      WR_ADDR <= '0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      fv_q  <= FRAME_VALID;
      WR_EN <= 1'b0;
      DONE  <= 1'b0;
      if (PIXEL_VALID) begin
        xb <= xb_nxt;
        yb <= yb_nxt;
      end
      case (state)
        IDLE: if (START) begin
          state <= ARM;
          ERR   <= 1'b0;
          wcnt  <= '0;
          full  <= 1'b0;
        end
        ARM: if (fv_rise) state <= CAPT;
        CAPT: begin
          if (samp) begin
            if (full) ERR <= 1'b1;
            else begin
              WR_EN   <= 1'b1;
              WR_ADDR <= wcnt;
              if (wcnt == LAST) full <= 1'b1;
              else              wcnt <= wcnt + 1'b1;
            end
          end
          if (fv_fall) begin
            state <= scaler_pkg::READY;
            DONE  <= 1'b1;
            if (!(full || (samp && wcnt == LAST))) ERR <= 1'b1;
          end
        end
        scaler_pkg::READY: if (RELEASE) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY  = (state == ARM) || (state == CAPT);
  assign READY = (state == scaler_pkg::READY);

  scaler_rd_arb #(.ADDR_W(ADDR_W)) u_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       ((state == scaler_pkg::READY) && !RELEASE),
    .det_req  (DET_REQ),
    .det_addr (DET_ADDR),
    .pv_req   (PV_REQ),
    .pv_addr  (PV_ADDR),
    .det_gnt  (DET_GNT),
    .pv_gnt   (PV_GNT),
    .rd_en    (RD_EN),
    .rd_addr  (RD_ADDR)
  );

endmodule
